// File: rtl/seq_divider.sv
// Sequential 4-bit signed divider: one restoring step per clock on operand
// magnitudes, sign fix-up in a final cycle, fast paths for /0 and -8/-1.
`timescale 1ns/1ps

module seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero,
    output logic       Overflow,
    output logic       Zero
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] FIX    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;
    logic [1:0] count;
    logic [3:0] a_shift;
    logic [3:0] b_mag;
    logic [3:0] rem;
    logic [3:0] quo;
    logic       sign_a;
    logic       sign_b;

    logic [3:0] a_abs;
    logic [3:0] b_abs;
    logic       div_by_zero;
    logic       too_big;
    logic [4:0] rem_shift;
    logic [4:0] diff;
    logic [3:0] q_fix;
    logic [3:0] r_fix;

    assign a_abs       = A[3] ? 4'd0 - A : A;
    assign b_abs       = B[3] ? 4'd0 - B : B;
    assign div_by_zero = (B == 4'd0);
    assign too_big     = (A == 4'b1000) && (B == 4'b1111);

    // The remainder stays below |B| <= 8, so the shifted value fits in 5 bits
    // and bit 4 of the difference is its sign.
    assign rem_shift = {rem, a_shift[3]};
    assign diff      = rem_shift - {1'b0, b_mag};

    assign q_fix = (sign_a ^ sign_b) ? 4'd0 - quo : quo;
    assign r_fix = sign_a ? 4'd0 - rem : rem;

    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = (div_by_zero || too_big) ? DONE : DIVIDE;
            DIVIDE:  if (count == 2'd3) next_state = FIX;
            FIX:     next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the reset branch sits inside the clocked block, so reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= 2'd0;
            a_shift  <= 4'd0;
            b_mag    <= 4'd0;
            rem      <= 4'd0;
            quo      <= 4'd0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            Q        <= 4'd0;
            R        <= 4'd0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            DivZero  <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
        end else begin
            state <= next_state;
            Busy  <= (next_state != IDLE);
            Done  <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (Start) begin
                        count   <= 2'd0;
                        a_shift <= a_abs;
                        b_mag   <= b_abs;
                        rem     <= 4'd0;
                        quo     <= 4'd0;
                        sign_a  <= A[3];
                        sign_b  <= B[3];
                        if (div_by_zero) begin
                            Q        <= 4'b1111;
                            R        <= A;
                            DivZero  <= 1'b1;
                            Overflow <= 1'b0;
                            Zero     <= 1'b0;
                        end else if (too_big) begin
                            Q        <= 4'b1000;
                            R        <= 4'd0;
                            DivZero  <= 1'b0;
                            Overflow <= 1'b1;
                            Zero     <= 1'b0;
                        end
                    end
                end
                DIVIDE: begin
                    rem     <= diff[4] ? rem_shift[3:0] : diff[3:0];
                    quo     <= {quo[2:0], ~diff[4]};
                    a_shift <= {a_shift[2:0], 1'b0};
                    count   <= count + 2'd1;
                end
                FIX: begin
                    Q        <= q_fix;
                    R        <= r_fix;
                    Zero     <= (q_fix == 4'd0);
                    DivZero  <= 1'b0;
                    Overflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed literal cases, reset abort,
// exhaustive and random operands against a truncating-division model.
`timescale 1ns/1ps

module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       div_zero;
    logic       overflow;
    logic       zero;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (start),
        .A        (a),
        .B        (b),
        .Q        (q),
        .R        (r),
        .Busy     (busy),
        .Done     (done),
        .DivZero  (div_zero),
        .Overflow (overflow),
        .Zero     (zero)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ov;
        logic       zero;
        int         due;
    } res_t;

    res_t pending[$];
    res_t held;
    res_t popped;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    bit   in_reset = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Signed truncating division on integers, plus the two special cases.
    function automatic res_t model(input logic [3:0] a_in, input logic [3:0] b_in);
        res_t res;
        int   ai;
        int   bi;
        int   qi;
        int   ri;
        ai = $signed(a_in);
        bi = $signed(b_in);
        res.dz  = 1'b0;
        res.ov  = 1'b0;
        res.due = 0;
        if (bi == 0) begin
            res.q  = 4'b1111;
            res.r  = a_in;
            res.dz = 1'b1;
        end else if (ai == -8 && bi == -1) begin
            res.q  = 4'b1000;
            res.r  = 4'd0;
            res.ov = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            res.q = qi[3:0];
            res.r = ri[3:0];
        end
        res.zero = (res.q == 4'd0);
        return res;
    endfunction

    // Output compare: every cycle the registered outputs must equal the last result.
    always @(negedge clk) begin
        if (chk_en) begin
            if (in_reset) begin
                check("done_in_reset", done, 0);
            end else begin
                if (done === 1'b1) begin
                    if (pending.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got Done=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        popped = pending.pop_front();
                        check("done_cycle", cyc, popped.due);
                        check("busy_at_done", busy, 1);
                        held = popped;
                    end
                end
                check("q", q, held.q);
                check("r", r, held.r);
                check("div_zero", div_zero, held.dz);
                check("overflow", overflow, held.ov);
                check("zero", zero, held.zero);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || done !== 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("wait_idle");
    endtask

    task automatic op(input logic [3:0] a_in, input logic [3:0] b_in,
                      input bit poke_busy, input bit poke_done);
        res_t e;
        bit   fast;
        int   n;
        wait_idle();
        a = a_in;
        b = b_in;
        start = 1'b1;
        e = model(a_in, b_in);
        fast = (b_in == 4'd0) || (a_in == 4'b1000 && b_in == 4'b1111);
        @(posedge clk);
        #1;
        e.due = cyc + (fast ? 0 : 5);
        pending.push_back(e);
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        if (poke_busy && !fast) begin
            @(negedge clk);
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (poke_done) begin
            n = 0;
            @(negedge clk);
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) timeout("wait_done");
            else begin
                start = 1'b1;
                a = 4'($urandom);
                b = 4'($urandom);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (pending.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("drain");
        @(negedge clk);
    endtask

    task automatic lit(input logic [3:0] a_in, input logic [3:0] b_in,
                       input logic [3:0] eq, input logic [3:0] er,
                       input bit edz, input bit eov, input bit ez, input bit poke);
        op(a_in, b_in, poke, 1'b0);
        drain();
        check("lit_q", q, eq);
        check("lit_r", r, er);
        check("lit_div_zero", div_zero, edz);
        check("lit_overflow", overflow, eov);
        check("lit_zero", zero, ez);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"}, q, 0);
        check({tag, "_r"}, r, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_div_zero"}, div_zero, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_zero"}, zero, 0);
    endtask

    task automatic abort_test();
        wait_idle();
        a = 4'd5;
        b = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        in_reset = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst_n = 1'b1;
        held = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0};
        in_reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        held = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        in_reset = 1'b0;

        lit(4'd7,    4'd2,    4'b0011, 4'b0001, 0, 0, 0, 0);
        lit(4'b1001, 4'd2,    4'b1101, 4'b1111, 0, 0, 0, 0);
        lit(4'd7,    4'b1110, 4'b1101, 4'b0001, 0, 0, 0, 0);
        lit(4'd5,    4'd0,    4'b1111, 4'b0101, 1, 0, 0, 0);
        lit(4'b1000, 4'b1111, 4'b1000, 4'b0000, 0, 1, 0, 0);
        lit(4'b1000, 4'd1,    4'b1000, 4'b0000, 0, 0, 0, 0);
        lit(4'd1,    4'd3,    4'b0000, 4'b0001, 0, 0, 1, 0);
        lit(4'd7,    4'd2,    4'b0011, 4'b0001, 0, 0, 0, 1);

        abort_test();
        lit(4'd6, 4'd3, 4'd2, 4'd0, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op(4'(i), 4'(j), (j % 5) == 0, (i % 7) == 0);
            end
        end

        repeat (200) begin
            ra = 4'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                ra = 4'b1000;
                rb = 4'b1111;
            end
            op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        drain();
        check("pending_empty", pending.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL be a single clock domain; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 Start  input  1  request pulse; operands accepted when Start=1 in IDLE.
REQ-005 A  input  4  dividend, two's complement.
REQ-006 B  input  4  divisor, two's complement.
REQ-007 Q  output  4  quotient, two's complement, truncated toward zero.
REQ-008 R  output  4  remainder, two's complement, sign of dividend.
REQ-009 Busy  output  1  high in every state except IDLE.
REQ-010 Done  output  1  one-cycle result-valid pulse.
REQ-011 DivZero  output  1  divide-by-zero flag, valid with Done.
REQ-012 Overflow  output  1  quotient-not-representable flag, valid with Done.
REQ-013 Zero  output  1  Q==0, valid with Done.

Function
REQ-014 States SHALL be IDLE, DIVIDE, FIX, DONE.
REQ-015 IDLE, Start=1: SHALL register A and B; compute |A| and |B| as 4-bit unsigned (|-8| = 4'b1000); record sign bits; clear the iteration counter; go to DIVIDE.
REQ-016 IDLE, Start=1, B==0: fast path; SHALL go directly to DONE with Q=4'b1111, R=A, DivZero=1, Overflow=0.
REQ-017 IDLE, Start=1, A==4'b1000 and B==4'b1111: fast path; SHALL go directly to DONE with Q=4'b1000, R=0, Overflow=1, DivZero=0.
REQ-018 DIVIDE SHALL do one restoring step per clock, MSB first, on a 5-bit partial remainder: shift left and bring in the next |A| bit; subtract |B|; if the result is non-negative, keep it and set the quotient bit to 1, else restore and set it to 0.
REQ-019 DIVIDE SHALL last exactly 4 cycles (2-bit counter 0..3) and then go to FIX.
REQ-020 FIX SHALL compute the results in one cycle: Q = -mag_q if sign(A)!=sign(B), else mag_q; R = -mag_r if A negative, else mag_r; all arithmetic modulo 16.
REQ-021 FIX SHALL register Q, R, Zero, DivZero=0 and Overflow=0, then go to DONE.
REQ-022 DONE SHALL hold Done=1 for exactly one cycle and return to IDLE on the next edge.
REQ-023 Normal-path latency: Start accepted at edge 0; Done high in the cycle after edge 5. Fast-path latency: Done high in the cycle after edge 0.
REQ-024 Q, R and the flags SHALL hold their values after Done until the next result is registered.
REQ-025 Start while Busy=1 SHALL be ignored, with no effect on state or operands.
REQ-026 Start=1 in the same cycle Done=1 SHALL be ignored; it is accepted only once the block is back in IDLE.
REQ-027 Changes on A and B after acceptance SHALL NOT affect the result in progress.
REQ-028 Zero SHALL equal (Q==0) in the DONE cycle for every path, including the fast paths.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE and clear Q, R, Busy, Done, DivZero, Overflow, Zero and the counter to 0.
REQ-030 Reset asserted mid-operation (DIVIDE or FIX) SHALL abort it with no Done pulse; the next Start after release SHALL run normally.
REQ-031 All outputs SHALL be registered; no combinational path from the inputs to the outputs.

Verification
REQ-032 A=7, B=2, Start -> after 6 edges Done=1, Q=4'b0011, R=4'b0001, flags 0.
REQ-033 A=-7 (1001), B=2 -> Q=4'b1101 (-3), R=4'b1111 (-1); A=7, B=-2 -> Q=4'b1101, R=4'b0001.
REQ-034 A=5, B=0 -> Done the cycle after accept, DivZero=1, Q=4'b1111, R=4'b0101; A=-8, B=-1 -> Overflow=1, Q=4'b1000, R=0.
REQ-035 A=-8, B=1 -> Q=4'b1000, R=0, Overflow=0; A=1, B=3 -> Q=0, R=1, Zero=1.
REQ-036 Start pulsed in the 2nd DIVIDE cycle with different A and B -> ignored, first result unchanged; rst_n=0 in the 3rd DIVIDE cycle -> no Done, all outputs 0, then 6/3 gives Q=2, R=0.
REQ-037 Exhaustive check of all 256 A/B pairs against a reference truncating-division model.
